// File: rtl/booth_multp_seq.sv
// ---------------------------------------------------------------------------
// booth_multp_seq
//
// Iterative radix-4 Booth multiplier with valid/ready handshakes. Each RUN
// cycle retires PAIRS_PER_CYCLE Booth digits into a carry-save accumulator.
// The result is presented as a redundant sum/carry pair whose modular sum is
// the product, signed or unsigned per transaction.
//
// Optional feature macro: BOOTH_MULTP_FINAL_ADD_EN
//   When defined, an extra cycle resolves the pair so that out0 holds the
//   product and out1 is zero (latency N+1 instead of N).
//
// Parameters
//   A_WIDTH          multiplier width (>= 2)
//   B_WIDTH          multiplicand width (>= 1)
//   PAIRS_PER_CYCLE  Booth digits consumed per RUN cycle (1..D)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   block can accept a beat (function of state, rst, out_ready)
//   a, b       multiplier / multiplicand
//   tc         1 = two's complement operands, 0 = unsigned
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer accepts the result
//   out0/out1  carry-save sum / carry words, OUT_WIDTH = A+B+2 bits
//   busy       an operation is in flight or waiting to be consumed
// ---------------------------------------------------------------------------
module booth_multp_seq #(
    parameter int A_WIDTH         = 24,
    parameter int B_WIDTH         = 24,
    parameter int PAIRS_PER_CYCLE = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [A_WIDTH-1:0]         a,
    input  logic [B_WIDTH-1:0]         b,
    input  logic                       tc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [A_WIDTH+B_WIDTH+1:0] out0,
    output logic [A_WIDTH+B_WIDTH+1:0] out1,
    output logic                       busy
);

    localparam int D         = A_WIDTH / 2 + 1;
    localparam int OUT_WIDTH = A_WIDTH + B_WIDTH + 2;
    localparam int N         = (D + PAIRS_PER_CYCLE - 1) / PAIRS_PER_CYCLE;
    localparam int AP_WIDTH  = A_WIDTH + 3;
    localparam int SHIFT     = 2 * PAIRS_PER_CYCLE;
    localparam int CNT_WIDTH = $clog2(N * PAIRS_PER_CYCLE + 1);

    // Digit index of the first digit handled in the final RUN cycle.
    localparam logic [CNT_WIDTH-1:0] LAST_DIG = CNT_WIDTH'((N - 1) * PAIRS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
`ifdef BOOTH_MULTP_FINAL_ADD_EN
        ,
        ADD  = 2'd3
`endif
    } state_t;

    state_t                 state, state_n;
    logic                   accept;
    logic                   last_run;
    logic                   a_sign, b_sign;

    // a_sh holds the padded multiplier shifted so the current digits sit at
    // the bottom; b_sh holds the multiplicand pre-shifted to match.
    logic [AP_WIDTH-1:0]    a_sh;
    logic [OUT_WIDTH-1:0]   b_sh;
    logic [OUT_WIDTH-1:0]   acc_s, acc_c;
    logic [OUT_WIDTH-1:0]   sum_n, carry_n, pp_j, maj_j;
    logic [CNT_WIDTH-1:0]   dig;

    assign a_sign   = tc & a[A_WIDTH-1];
    assign b_sign   = tc & b[B_WIDTH-1];
    assign accept   = in_valid && in_ready;
    assign last_run = (dig == LAST_DIG);

    // Radix-4 Booth recoding of one digit against the (already shifted)
    // multiplicand; negation wraps at OUT_WIDTH.
    function automatic logic [OUT_WIDTH-1:0] booth_pp(
        input logic [2:0]           digit,
        input logic [OUT_WIDTH-1:0] mcand
    );
        logic [OUT_WIDTH-1:0] pp;
        case (digit)
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand << 1;
            3'b100:         pp = -(mcand << 1);
            3'b101, 3'b110: pp = -mcand;
            default:        pp = '0;
        endcase
        return pp;
    endfunction

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // case leaves a signal unassigned and no latch is inferred.
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = RUN;
            end
            RUN: begin
                busy = 1'b1;
`ifdef BOOTH_MULTP_FINAL_ADD_EN
                if (last_run) state_n = ADD;
`else
                if (last_run) state_n = DONE;
`endif
            end
`ifdef BOOTH_MULTP_FINAL_ADD_EN
            ADD: begin
                busy    = 1'b1;
                state_n = DONE;
            end
`endif
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // Handing off and accepting the next beat share one cycle.
                in_ready  = out_ready;
                if (out_ready) state_n = in_valid ? RUN : IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (rst) in_ready = 1'b0;
    end

    // ------------------------------------------------- carry-save compress
    always_comb begin
        sum_n   = acc_s;
        carry_n = acc_c;
        pp_j    = '0;
        maj_j   = '0;
        // NOTE: blocking assignments here are deliberate: each 3:2 stage
        // consumes the sum/carry produced by the previous stage in the chain.
        for (int j = 0; j < PAIRS_PER_CYCLE; j++) begin
            pp_j    = booth_pp(a_sh[2*j +: 3], b_sh << (2 * j));
            maj_j   = (sum_n & carry_n) | (sum_n & pp_j) | (carry_n & pp_j);
            sum_n   = sum_n ^ carry_n ^ pp_j;
            carry_n = maj_j << 1;
        end
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc_s <= '0;
            acc_c <= '0;
            dig   <= '0;
            out0  <= '0;
            out1  <= '0;
        end else if (accept) begin
            a_sh  <= {a_sign, a_sign, a, 1'b0};
            b_sh  <= {{(OUT_WIDTH - B_WIDTH){b_sign}}, b};
            acc_s <= '0;
            acc_c <= '0;
            dig   <= '0;
        end else if (state == RUN) begin
            acc_s <= sum_n;
            acc_c <= carry_n;
            // Arithmetic shift refills with the sign, so digits past D-1
            // recode to 000/111 and contribute zero.
            a_sh  <= AP_WIDTH'($signed(a_sh) >>> SHIFT);
            b_sh  <= b_sh << SHIFT;
            dig   <= dig + CNT_WIDTH'(PAIRS_PER_CYCLE);
`ifndef BOOTH_MULTP_FINAL_ADD_EN
            if (last_run) begin
                out0 <= sum_n;
                out1 <= carry_n;
            end
`endif
        end
`ifdef BOOTH_MULTP_FINAL_ADD_EN
        else if (state == ADD) begin
            out0 <= acc_s + acc_c;
            out1 <= '0;
        end
`endif
    end

endmodule
